// File: rtl/soc_pll_reset_ctrl.sv
// soc_pll_reset_ctrl: sequences the PLL reset, qualifies the synchronized
// lock indication and holds the SoC in reset until lock has been continuously
// stable. A lock timeout or a loss of lock sends the PLL back into reset.
// Optional retry limit: define SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN to add a
// terminal FAULT state entered after MAX_RETRIES consecutive lock timeouts.
module soc_pll_reset_ctrl #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
    parameter int MAX_RETRIES         = 8,
`endif
    parameter int CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             fault
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
        ST_FAULT,
`endif
        ST_RUN
    } state_t;

    state_t                 state_reg;
    logic [TW-1:0]          timer_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   pll_rst_reg;
    logic                   sys_rst_reg;
    logic [CNT_W-1:0]       lock_loss_cnt_reg;
    logic [CNT_W-1:0]       timeout_cnt_reg;
    logic                   locked_s;

`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
    logic [RW-1:0] retry_reg;
    logic          fault_reg;
`endif

    assign locked_s = sync_reg[SYNC_STAGES-1];

    // Multi-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Sequencing FSM; outputs are registered alongside each state change.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg         <= ST_PLL_RESET;
            timer_reg         <= '0;
            pll_rst_reg       <= 1'b1;
            sys_rst_reg       <= 1'b1;
            lock_loss_cnt_reg <= '0;
            timeout_cnt_reg   <= '0;
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
            retry_reg         <= '0;
            fault_reg         <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_PLL_RESET: begin
                    if (timer_reg == RST_LAST) begin
                        state_reg   <= ST_WAIT_LOCK;
                        timer_reg   <= '0;
                        pll_rst_reg <= 1'b0;
                        sys_rst_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock takes priority over a simultaneous timeout.
                    if (locked_s) begin
                        state_reg <= ST_STABLE;
                        timer_reg <= '0;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        timer_reg   <= '0;
                        pll_rst_reg <= 1'b1;
                        if (timeout_cnt_reg != CNT_MAX)
                            timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
                        if (retry_reg == RETRY_LAST) begin
                            state_reg <= ST_FAULT;
                            fault_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_PLL_RESET;
                            retry_reg <= retry_reg + RW'(1);
                        end
`else
                        state_reg <= ST_PLL_RESET;
`endif
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                ST_STABLE: begin
                    // Any observed low restarts qualification from WAIT_LOCK.
                    if (!locked_s) begin
                        state_reg <= ST_WAIT_LOCK;
                        timer_reg <= '0;
                    end else if (timer_reg == STABLE_LAST) begin
                        state_reg   <= ST_RUN;
                        timer_reg   <= '0;
                        sys_rst_reg <= 1'b0;
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
                        retry_reg   <= '0;
`endif
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_reg   <= ST_PLL_RESET;
                        timer_reg   <= '0;
                        pll_rst_reg <= 1'b1;
                        sys_rst_reg <= 1'b1;
                        if (lock_loss_cnt_reg != CNT_MAX)
                            lock_loss_cnt_reg <= lock_loss_cnt_reg + CNT_W'(1);
                    end
                end
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
                ST_FAULT: begin
                    pll_rst_reg <= 1'b1;
                    sys_rst_reg <= 1'b1;
                    fault_reg   <= 1'b1;
                end
`endif
                default: begin
                    state_reg   <= ST_PLL_RESET;
                    timer_reg   <= '0;
                    pll_rst_reg <= 1'b1;
                    sys_rst_reg <= 1'b1;
                end
            endcase
        end
    end

    assign pll_rst       = pll_rst_reg;
    assign sys_rst       = sys_rst_reg;
    assign lock_loss_cnt = lock_loss_cnt_reg;
    assign timeout_cnt   = timeout_cnt_reg;
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
    assign fault         = fault_reg;
`else
    assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_soc_pll_reset_ctrl.sv
// Testbench for soc_pll_reset_ctrl: directed scenarios plus randomized lock
// and reset activity, compared every cycle against a phase/duration model.
module tb_soc_pll_reset_ctrl;

    localparam int S = 2;
    localparam int P = 4;
    localparam int L = 8;
    localparam int T = 32;
    localparam int CW = 4;
    localparam int CMAX = 15;
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
    localparam int MAXR = 3;
`endif

    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAULT  = 4;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] timeout_cnt;
    logic          fault;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: current phase, cycles spent in it, lock-view delay line.
    int m_phase = PH_RESET;
    int m_age = 1;
    int m_loss = 0;
    int m_tmo = 0;
    int m_retries = 0;
    bit m_sync [S];

    soc_pll_reset_ctrl #(
        .SYNC_STAGES(S),
        .PLL_RST_CYCLES(P),
        .LOCK_STABLE_CYCLES(L),
        .LOCK_TIMEOUT_CYCLES(T),
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
        .MAX_RETRIES(MAXR),
`endif
        .CNT_W(CW)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt(timeout_cnt),
        .fault(fault)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic m_enter(input int ph);
        m_phase = ph;
        m_age = 1;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        bit ls;
        ls = m_sync[S-1];
        if (rst) begin
            for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
            m_enter(PH_RESET);
            m_loss = 0;
            m_tmo = 0;
            m_retries = 0;
            return;
        end
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = pll_locked;
        case (m_phase)
            PH_RESET: if (m_age == P) m_enter(PH_WAIT); else m_age++;
            PH_WAIT: begin
                if (ls) m_enter(PH_STABLE);
                else if (m_age == T) begin
                    m_tmo = sat_inc(m_tmo);
                    m_retries++;
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
                    if (m_retries >= MAXR) m_enter(PH_FAULT);
                    else m_enter(PH_RESET);
`else
                    m_enter(PH_RESET);
`endif
                end else m_age++;
            end
            PH_STABLE: begin
                if (!ls) m_enter(PH_WAIT);
                else if (m_age == L) begin
                    m_enter(PH_RUN);
                    m_retries = 0;
                end else m_age++;
            end
            PH_RUN: begin
                if (!ls) begin
                    m_enter(PH_RESET);
                    m_loss = sat_inc(m_loss);
                end
            end
            default: m_age++;
        endcase
    endtask

    // One clock: model update at the edge, DUT compared 1 time unit later.
    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        check("pll_rst", int'(pll_rst), (m_phase == PH_RESET || m_phase == PH_FAULT) ? 1 : 0);
        check("sys_rst", int'(sys_rst), (m_phase != PH_RUN) ? 1 : 0);
        check("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
        check("timeout_cnt", int'(timeout_cnt), m_tmo);
        check("fault", int'(fault), (m_phase == PH_FAULT) ? 1 : 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Count edges until sys_rst reaches val; -1 if the budget expires.
    task automatic edges_until_sysrst(input logic val, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (sys_rst == val) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int hold;

    initial begin
        // Reset state and no-lock behaviour.
        rst = 1'b1;
        pll_locked = 1'b0;
        steps(2);
        check("reset_pll_rst", int'(pll_rst), 1);
        check("reset_sys_rst", int'(sys_rst), 1);
        check("reset_cnts", int'(lock_loss_cnt) + int'(timeout_cnt), 0);
        rst = 1'b0;
        steps(600);
        check("sys_rst_no_lock", int'(sys_rst), 1);
`ifdef SOC_PLL_RESET_CTRL_RETRY_LIMIT_EN
        check("timeout_at_fault", int'(timeout_cnt), MAXR);
        check("fault_set", int'(fault), 1);
        check("fault_pll_rst", int'(pll_rst), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("fault_cleared", int'(fault), 0);
`else
        check("timeout_saturated", int'(timeout_cnt), CMAX);
        check("fault_tied", int'(fault), 0);
`endif
        $display("[TB] no-lock sequence done, timeout_cnt=%0d", timeout_cnt);

        // Lock 10 cycles into WAIT_LOCK -> release 11 edges later.
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(P + 10);
        pll_locked = 1'b1;
        edges_until_sysrst(1'b0, 50, n);
        check("release_latency", n, S + L + 1);
        check("release_pll_rst", int'(pll_rst), 0);
        $display("[TB] release after %0d edges", n);

        // Loss of lock in RUN, then re-lock.
        pll_locked = 1'b0;
        edges_until_sysrst(1'b1, 20, n);
        check("loss_latency", n, S + 1);
        check("loss_pll_rst", int'(pll_rst), 1);
        check("loss_cnt_1", int'(lock_loss_cnt), 1);
        pll_locked = 1'b1;
        edges_until_sysrst(1'b0, 40, n);
        check("relock_latency", n, P + 1 + L);
        $display("[TB] loss detected, relocked after %0d edges", n);

        // Two more losses, then rst pulse in RUN.
        for (int k = 0; k < 2; k++) begin
            pll_locked = 1'b0;
            edges_until_sysrst(1'b1, 20, n);
            pll_locked = 1'b1;
            edges_until_sysrst(1'b0, 40, n);
        end
        check("loss_cnt_3", int'(lock_loss_cnt), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_run_sys_rst", int'(sys_rst), 1);
        check("rst_run_pll_rst", int'(pll_rst), 1);
        check("rst_run_loss_cnt", int'(lock_loss_cnt), 0);
        $display("[TB] rst in RUN cleared counters");

        // Glitch low for 2 cycles at STABLE timer=5.
        pll_locked = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(P + 3);
        pll_locked = 1'b1;
        steps(S + 1 + 5);
        pll_locked = 1'b0;
        steps(2);
        pll_locked = 1'b1;
        edges_until_sysrst(1'b0, 40, n);
        check("glitch_release_latency", n, S + L + 1);
        $display("[TB] glitch restarted qualification, release after %0d edges", n);

        // Randomized lock activity with occasional resets.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                pll_locked = ~pll_locked;
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                   : int'($urandom_range(5, 60));
            end
            hold--;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        $display("[TB] random phase done, lock_loss_cnt=%0d timeout_cnt=%0d", lock_loss_cnt, timeout_cnt);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
